// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: default sizing, FSM state
// encoding and the one-hot to index conversion used to drive the owner mux.
package bus_pkg;

    localparam int N_MASTERS_DEF = 4;
    localparam int MAX_HOLD_DEF  = 16;
    localparam int OWNER_W_DEF   = $clog2(N_MASTERS_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Converts a one-hot vector (up to 8 masters) to its bit index.
    // The input is one-hot by construction, so OR-ing the indices of the
    // set bits yields the index without a priority chain.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Among the requesters not excluded,
// the winner is the first one found when searching upward from last+1,
// wrapping to index 0.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = N_MASTERS_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    input  logic [N-1:0] exclude,
    output logic [N-1:0] winner,
    output logic         valid
);

    logic [N-1:0] cand_s;
    logic [N-1:0] hi_win_s;
    logic [N-1:0] lo_win_s;
    logic         hi_found_s;
    logic         lo_found_s;

    // Lowest candidate above last wins; otherwise the lowest candidate
    // overall, which is the wrap-around part of the search.
    always_comb begin
        cand_s     = req & ~exclude;
        hi_win_s   = '0;
        lo_win_s   = '0;
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        for (int j = 0; j < N; j++) begin
            hi_win_s[j] = cand_s[j] && (j > int'(last)) && !hi_found_s;
            hi_found_s  = hi_found_s | hi_win_s[j];
            lo_win_s[j] = cand_s[j] && !lo_found_s;
            lo_found_s  = lo_found_s | lo_win_s[j];
        end
        winner = hi_found_s ? hi_win_s : lo_win_s;
        valid  = lo_found_s;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a hold limit. Produces a registered one-hot
// grant, the owner index for the address/data mux, a busy flag and a
// one-cycle preemption pulse when the hold limit revokes a grant.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int MAX_HOLD  = MAX_HOLD_DEF,
    parameter int OWNER_W   = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grnt,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam logic [7:0]         HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic [OWNER_W-1:0] LAST_RST = OWNER_W'(N_MASTERS - 1);

    arb_state_t           state_r;
    logic [OWNER_W-1:0]   last_r;
    logic [7:0]           hold_cnt_r;
    logic [N_MASTERS-1:0] grnt_r;
    logic [OWNER_W-1:0]   owner_r;
    logic                 busy_r;
    logic                 preempt_r;

    arb_state_t           state_n_s;
    logic [OWNER_W-1:0]   last_n_s;
    logic [7:0]           hold_n_s;
    logic [N_MASTERS-1:0] grnt_n_s;
    logic [OWNER_W-1:0]   owner_n_s;
    logic                 preempt_n_s;

    logic [N_MASTERS-1:0] win_s;
    logic                 win_valid_s;
    logic [OWNER_W-1:0]   win_idx_s;
    logic                 own_req_s;
    logic                 other_req_s;

    // The current owner is masked out of the search; this serves both the
    // release path (its request is low anyway) and the preemption path.
    rr_pick #(
        .N (N_MASTERS),
        .W (OWNER_W)
    ) u_rr_pick (
        .req     (req),
        .last    (last_r),
        .exclude (grnt_r),
        .winner  (win_s),
        .valid   (win_valid_s)
    );

    // Decode the winner index and classify the requests against the owner.
    always_comb begin
        win_idx_s   = OWNER_W'(onehot_to_idx(8'(win_s)));
        own_req_s   = |(req & grnt_r);
        other_req_s = |(req & ~grnt_r);
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_n_s   = state_r;
        last_n_s    = last_r;
        hold_n_s    = hold_cnt_r;
        grnt_n_s    = grnt_r;
        owner_n_s   = owner_r;
        preempt_n_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_n_s = GRANT;
                    grnt_n_s  = win_s;
                    owner_n_s = win_idx_s;
                    last_n_s  = win_idx_s;
                    hold_n_s  = 8'd0;
                end else begin
                    grnt_n_s  = '0;
                end
            end
            GRANT: begin
                if (!own_req_s) begin
                    if (win_valid_s) begin
                        grnt_n_s  = win_s;
                        owner_n_s = win_idx_s;
                        last_n_s  = win_idx_s;
                        hold_n_s  = 8'd0;
                    end else begin
                        state_n_s = IDLE;
                        grnt_n_s  = '0;
                        hold_n_s  = 8'd0;
                    end
                end else if ((hold_cnt_r == HOLD_LIM) && other_req_s) begin
                    grnt_n_s    = win_s;
                    owner_n_s   = win_idx_s;
                    last_n_s    = win_idx_s;
                    hold_n_s    = 8'd0;
                    preempt_n_s = 1'b1;
                end else if (hold_cnt_r != HOLD_LIM) begin
                    hold_n_s = hold_cnt_r + 8'd1;
                end else begin
                    // Sole requester at the limit: saturate, never wrap.
                    hold_n_s = hold_cnt_r;
                end
            end
            default: begin
                state_n_s = IDLE;
                grnt_n_s  = '0;
                hold_n_s  = 8'd0;
            end
        endcase
    end

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            last_r     <= LAST_RST;
            hold_cnt_r <= 8'd0;
            grnt_r     <= '0;
            owner_r    <= '0;
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            last_r     <= last_n_s;
            hold_cnt_r <= hold_n_s;
            grnt_r     <= grnt_n_s;
            owner_r    <= owner_n_s;
            busy_r     <= |grnt_n_s;
            preempt_r  <= preempt_n_s;
        end
    end

    assign grnt    = grnt_r;
    assign owner   = owner_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (4 masters, hold limit 16). Each task
// drives req, pushes the expected post-edge outputs and compares them
// after the edge.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grnt;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    typedef struct packed {
        logic [3:0] grnt;
        logic [1:0] owner;
        logic       busy;
        logic       preempt;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bus_arbiter #(
        .N_MASTERS (4),
        .MAX_HOLD  (16),
        .OWNER_W   (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grnt    (grnt),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [3:0] g, input logic [1:0] o,
                                input logic b, input logic p);
        obs_t r;
        r.grnt    = g;
        r.owner   = o;
        r.busy    = b;
        r.preempt = p;
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t g;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req = 4'b1111;
            exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] rq [4];
        obs_t       ex [4];
        obs_t       e;
        obs_t       g;
        rq = '{4'b0001, 4'b0000, 4'b0100, 4'b0000};
        ex = '{mk(4'b0001, 2'd0, 1'b1, 1'b0), mk(4'b0000, 2'd0, 1'b0, 1'b0),
               mk(4'b0100, 2'd2, 1'b1, 1'b0), mk(4'b0000, 2'd2, 1'b0, 1'b0)};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            req = rq[k];
            exp_q.push_back(ex[k]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single step %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
    endtask

    // All four request; each owner releases after three granted cycles and
    // re-raises its request one cycle later.
    task automatic test_rotation();
        obs_t       e;
        obs_t       g;
        logic [3:0] rq;
        int         o;
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            o  = (k / 3) % 4;
            rq = 4'b1111;
            if ((k % 3 == 0) && (k > 0)) rq[(k / 3) - 1] = 1'b0;
            req = rq;
            exp_q.push_back(mk(4'(4'b0001 << o), 2'(o), 1'b1, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL rotation step %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
    endtask

    // Master 2 holds; master 0 joins from the fifth edge. Master 2 keeps the
    // bus for 16 cycles, then the grant moves to master 0 with one pulse.
    task automatic test_preempt();
        obs_t e;
        obs_t g;
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            req = (k < 5) ? 4'b0100 : 4'b0101;
            if (k <= 16)      exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
            else if (k == 17) exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1));
            else              exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL preempt edge %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
    endtask

    // Master 1 alone for 100 cycles keeps the bus; the counter sits at its
    // limit, so a competitor appearing afterwards preempts on the next edge.
    task automatic test_solo_hold();
        obs_t e;
        obs_t g;
        apply_reset();
        for (int k = 0; k < 103; k++) begin
            req = (k < 100) ? 4'b0010 : 4'b0011;
            if (k < 100)       exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
            else if (k == 100) exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1));
            else               exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL solo_hold cycle %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
    endtask

    // Owner 3 releases on the edge where masters 0 and 2 request.
    task automatic test_back_to_back();
        logic [3:0] rq [3];
        obs_t       ex [3];
        obs_t       e;
        obs_t       g;
        rq = '{4'b1000, 4'b0101, 4'b0100};
        ex = '{mk(4'b1000, 2'd3, 1'b1, 1'b0), mk(4'b0001, 2'd0, 1'b1, 1'b0),
               mk(4'b0100, 2'd2, 1'b1, 1'b0)};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            req = rq[k];
            exp_q.push_back(ex[k]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
    endtask

    // Reset while master 2 owns the bus, then restart with 0110 held.
    task automatic test_reset_mid();
        logic [3:0] rq [4];
        logic       rs [4];
        obs_t       ex [4];
        obs_t       e;
        obs_t       g;
        rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0110};
        rs = '{1'b0, 1'b0, 1'b1, 1'b0};
        ex = '{mk(4'b0100, 2'd2, 1'b1, 1'b0), mk(4'b0100, 2'd2, 1'b1, 1'b0),
               mk(4'b0000, 2'd0, 1'b0, 1'b0), mk(4'b0010, 2'd1, 1'b1, 1'b0)};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            req   = rq[k];
            reset = rs[k];
            exp_q.push_back(ex[k]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = {grnt, owner, busy, preempt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid step %0d: got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         k, g.grnt, g.owner, g.busy, g.preempt,
                         e.grnt, e.owner, e.busy, e.preempt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_solo_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
